clk_divider_duty: RTL and testbench
===================================

CLK_DIVIDER_DUTY -- requirements
Module: clk_divider_duty

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the divide ratio and high-count.
REQ-002 Parameter DEFAULT_DIV, default 4, SHALL set the divide ratio N in force after reset.
REQ-003 Parameter DEFAULT_HIGH, default 2, SHALL set the high-count H in force after reset.
REQ-004 clockin  input  1  SHALL be the single clock; all logic runs on it.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 enable  input  1  SHALL gate division; 1 = count, 0 = hold.
REQ-007 cfg_load  input  1  SHALL be a one-cycle strobe requesting capture of div_ratio, high_count and duty_mode.
REQ-008 div_ratio  input  WIDTH  SHALL give the requested divide ratio N.
REQ-009 high_count  input  WIDTH  SHALL give the requested high-time H, in clockin cycles (mode 0 only).
REQ-010 duty_mode  input  1  SHALL select the duty mode: 0 = programmed H, 1 = exact 50%.
REQ-011 clockout  output  1  SHALL carry the divided clock.
REQ-012 tick  output  1  SHALL pulse high for one cycle at the start of each output period.
REQ-013 cfg_pending  output  1  SHALL be high while an accepted configuration awaits application.
REQ-014 cfg_err  output  1  SHALL pulse high for one cycle when a load is rejected.

Function
REQ-015 Counter cnt SHALL run 0..N-1 on rising clockin edges while enable=1, wrapping N-1 -> 0.
REQ-016 Mode 0: the registered clockout SHALL be 1 when cnt<H and 0 otherwise, updated on the same edge as cnt; high time = H cycles, low time = N-H cycles.
REQ-017 Mode 1, even N: the block SHALL use H=N/2 internally, giving exactly 50% duty.
REQ-018 Mode 1, odd N: a rising-edge flop SHALL be high for cnt<(N-1)/2, a falling-edge flop SHALL copy it half a cycle later, and clockout SHALL be their OR, giving a high time of N/2 cycles.
REQ-019 tick SHALL be 1 exactly in the cycles where cnt==0 and enable=1.
REQ-020 First edge with enable=1 after reset release or re-enable: cnt=0, clockout=1, tick=1.
REQ-021 Validity: a load SHALL be accepted only if N>=2 and (mode 1, or 1<=H<=N-1); otherwise cfg_err=1 next cycle and the active and pending configurations stay unchanged.
REQ-022 An accepted load while enable=1 SHALL set cfg_pending and apply at the next wrap (edge where cnt goes N-1 -> 0); the current period always completes with the old configuration.
REQ-023 An accepted load while enable=0 SHALL apply on the next edge; cfg_pending is not set.
REQ-024 A second accepted load before application SHALL overwrite the pending configuration (last wins).
REQ-025 cfg_load coincident with the wrap edge: the previously pending configuration SHALL apply on that edge and the new one SHALL become pending.
REQ-026 enable 1 -> 0: the next rising edge SHALL force cnt=0, clockout=0 and tick=0, and the falling-edge flop SHALL clear on the following falling edge.
REQ-027 N=2, H=1 SHALL produce 1010... with tick every second edge.

Reset
REQ-028 reset=1 SHALL asynchronously force cnt=0, clockout=0, tick=0, cfg_err=0 and cfg_pending=0, and clear both the rising- and falling-edge flops.
REQ-029 reset SHALL restore N=DEFAULT_DIV, H=DEFAULT_HIGH, mode 0, and discard any pending configuration.
REQ-030 Reset asserted mid-period SHALL drive clockout low immediately, with no completion of the current period.

Structure
REQ-031 Package clk_div_pkg SHALL hold the duty-mode enumeration (MODE_PROG, MODE_HALF) and the default DEFAULT_DIV/DEFAULT_HIGH constants.
REQ-032 Sub-module clk_div_cfg SHALL own validity checking, the pending/active configuration registers, cfg_pending and cfg_err.
REQ-033 The top level SHALL own the counter and the output flops.

Verification (10 ns clockin)
REQ-034 Reset 20 ns, enable=1, defaults -> clockout 1100 repeating (20 ns high / 20 ns low), tick every 40 ns.
REQ-035 cfg_load N=5, H=1 at cnt=1 -> old period finishes, then clockout is 10 ns high / 40 ns low; cfg_pending is high between the load and the wrap.
REQ-036 cfg_load N=3, mode 1 -> clockout is 15 ns high / 15 ns low, period 30 ns.
REQ-037 cfg_load N=4, H=4 -> one-cycle cfg_err pulse and clockout unchanged.
REQ-038 Reset asserted while clockout=1 -> clockout falls at once; after release the 1100 defaults resume.
REQ-039 enable low for 3 cycles mid-period -> clockout=0 and tick=0 while low; on re-enable, tick=1 and clockout=1 on the first edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and reset defaults for the duty-programmable clock divider
package clk_div_pkg;

    typedef enum logic {
        MODE_PROG = 1'b0,
        MODE_HALF = 1'b1
    } duty_mode_e;

    localparam int DEFAULT_DIV  = 4;
    localparam int DEFAULT_HIGH = 2;

endpackage

// File: rtl/clk_div_cfg.sv
// rtl/clk_div_cfg.sv - validates configuration loads and holds the active and pending divider settings
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RST_DIV  = 4,
    parameter int RST_HIGH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             wrap_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic [WIDTH-1:0] high_i,
    input  duty_mode_e       mode_i,
    output logic [WIDTH-1:0] cur_div_o,
    output duty_mode_e       cur_mode_o,
    output logic [WIDTH-1:0] nxt_div_o,
    output logic [WIDTH-1:0] nxt_high_o,
    output duty_mode_e       nxt_mode_o,
    output logic             pending_o,
    output logic             err_o
);

    logic [WIDTH-1:0] act_div_q, act_div_d;
    logic [WIDTH-1:0] act_high_q, act_high_d;
    duty_mode_e       act_mode_q, act_mode_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    duty_mode_e       pend_mode_q, pend_mode_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             load_ok;

    always_comb begin
        load_ok = load_i && (div_i >= WIDTH'(2)) &&
                  ((mode_i == MODE_HALF) || ((high_i != '0) && (high_i < div_i)));
    end

    always_comb begin
        act_div_d   = act_div_q;
        act_high_d  = act_high_q;
        act_mode_d  = act_mode_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        err_d       = load_i && !load_ok;

        // A waiting config takes over at a period boundary, or at once when the divider is idle.
        if (pend_q && (wrap_i || !enable_i)) begin
            act_div_d  = pend_div_q;
            act_high_d = pend_high_q;
            act_mode_d = pend_mode_q;
            pend_d     = 1'b0;
        end

        if (load_ok) begin
            if (enable_i) begin
                pend_div_d  = div_i;
                pend_high_d = high_i;
                pend_mode_d = mode_i;
                pend_d      = 1'b1;
            end else begin
                act_div_d  = div_i;
                act_high_d = high_i;
                act_mode_d = mode_i;
                pend_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_div_q   <= WIDTH'(RST_DIV);
            act_high_q  <= WIDTH'(RST_HIGH);
            act_mode_q  <= MODE_PROG;
            pend_div_q  <= '0;
            pend_high_q <= '0;
            pend_mode_q <= MODE_PROG;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            act_div_q   <= act_div_d;
            act_high_q  <= act_high_d;
            act_mode_q  <= act_mode_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    assign cur_div_o  = act_div_q;
    assign cur_mode_o = act_mode_q;
    assign nxt_div_o  = act_div_d;
    assign nxt_high_o = act_high_d;
    assign nxt_mode_o = act_mode_d;
    assign pending_o  = pend_q;
    assign err_o      = err_q;

endmodule

// File: rtl/clk_divider_duty.sv
// rtl/clk_divider_duty.sv - programmable clock divider with fixed high-time or exact 50% duty
module clk_divider_duty #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = clk_div_pkg::DEFAULT_DIV,
    parameter int DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic [WIDTH-1:0] high_count,
    input  logic             duty_mode,
    output logic             clockout,
    output logic             tick,
    output logic             cfg_pending,
    output logic             cfg_err
);

    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic                    rise_q, rise_d;
    logic                    tick_q, tick_d;
    logic                    fall_q;
    logic                    wrap;
    logic                    odd_half;
    logic [WIDTH-1:0]        high_eff;
    logic [WIDTH-1:0]        cur_div, nxt_div, nxt_high;
    clk_div_pkg::duty_mode_e cur_mode, nxt_mode;

    clk_div_cfg #(
        .WIDTH    (WIDTH),
        .RST_DIV  (DEFAULT_DIV),
        .RST_HIGH (DEFAULT_HIGH)
    ) u_cfg (
        .clk_i      (clockin),
        .rst_i      (reset),
        .enable_i   (enable),
        .wrap_i     (wrap),
        .load_i     (cfg_load),
        .div_i      (div_ratio),
        .high_i     (high_count),
        .mode_i     (clk_div_pkg::duty_mode_e'(duty_mode)),
        .cur_div_o  (cur_div),
        .cur_mode_o (cur_mode),
        .nxt_div_o  (nxt_div),
        .nxt_high_o (nxt_high),
        .nxt_mode_o (nxt_mode),
        .pending_o  (cfg_pending),
        .err_o      (cfg_err)
    );

    assign wrap = enable && run_q && (cnt_q >= (cur_div - WIDTH'(1)));

    // N>>1 is N/2 for even N and (N-1)/2 for odd N; the falling flop supplies the odd half cycle.
    always_comb begin
        high_eff = nxt_high;
        if (nxt_mode == clk_div_pkg::MODE_HALF) begin
            high_eff = nxt_div >> 1;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (enable && run_q && !wrap) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        run_d  = enable;
        rise_d = enable && (cnt_d < high_eff);
        tick_d = enable && (cnt_d == '0);
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            rise_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            rise_q <= rise_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(negedge clockin or posedge reset) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= rise_q;
        end
    end

    // run_q masks a stale falling-flop value during the half cycle after enable drops.
    assign odd_half = (cur_mode == clk_div_pkg::MODE_HALF) && cur_div[0] && run_q;
    assign clockout = rise_q | (odd_half & fall_q);
    assign tick     = tick_q;

endmodule

// File: tb/tb_clk_divider_duty.sv
// tb/tb_clk_divider_duty.sv - scoreboard bench for clk_divider_duty against a half-cycle period model
module tb_clk_divider_duty;

    localparam int WIDTH = 8;

    logic             clockin    = 1'b0;
    logic             reset      = 1'b1;
    logic             enable     = 1'b0;
    logic             cfg_load   = 1'b0;
    logic [WIDTH-1:0] div_ratio  = '0;
    logic [WIDTH-1:0] high_count = '0;
    logic             duty_mode  = 1'b0;
    logic             clockout, tick, cfg_pending, cfg_err;

    clk_divider_duty #(
        .WIDTH        (WIDTH),
        .DEFAULT_DIV  (4),
        .DEFAULT_HIGH (2)
    ) dut (
        .clockin     (clockin),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .div_ratio   (div_ratio),
        .high_count  (high_count),
        .duty_mode   (duty_mode),
        .clockout    (clockout),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clockin = ~clockin;

    typedef struct {
        logic out_a;
        logic out_b;
        logic tick;
        logic pend;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    int m_pos, m_n, m_h, p_n, p_h;
    bit m_run, m_mode, m_pv, p_mode, last_a;

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    endtask

    function automatic void model_reset();
        m_pos  = 0;
        m_run  = 1'b0;
        m_n    = 4;
        m_h    = 2;
        m_mode = 1'b0;
        m_pv   = 1'b0;
        last_a = 1'b0;
    endfunction

    // Drive one cycle of inputs, predict the state after the coming edge, then advance to edge+2ns.
    task automatic step(input bit en, input bit ld, input int n, input int h, input bit md);
        exp_t e;
        bit   ok, wrap;
        int   hh;
        enable     = en;
        cfg_load   = ld;
        div_ratio  = n[WIDTH-1:0];
        high_count = h[WIDTH-1:0];
        duty_mode  = md;
        ok    = ld && (n >= 2) && (md || (h >= 1 && h < n));
        e.err = ld && !ok;
        wrap  = en && m_run && (m_pos == m_n - 1);
        if (!en || !m_run || wrap) m_pos = 0;
        else m_pos = m_pos + 1;
        m_run = en;
        if (m_pv && (wrap || !en)) begin
            m_n = p_n; m_h = p_h; m_mode = p_mode; m_pv = 1'b0;
        end
        if (ok) begin
            if (en) begin
                p_n = n; p_h = h; p_mode = md; m_pv = 1'b1;
            end else begin
                m_n = n; m_h = h; m_mode = md; m_pv = 1'b0;
            end
        end
        // High time expressed in half cycles: N for exact 50%, 2H for programmed duty.
        hh      = m_mode ? m_n : 2 * m_h;
        e.tick  = en && (m_pos == 0);
        e.out_a = en && (2 * m_pos < hh);
        e.out_b = en && (2 * m_pos + 1 < hh);
        e.pend  = m_pv;
        last_a  = e.out_a;
        exp_q.push_back(e);
        @(posedge clockin);
        #2;
    endtask

    task automatic idle_to_pos(input int pos);
        int guard = 0;
        while (m_pos != pos && guard < 20) begin
            step(1, 0, 0, 0, 0);
            guard++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clockin);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clockout_first_half", clockout, e.out_a);
                check("tick", tick, e.tick);
                check("cfg_pending", cfg_pending, e.pend);
                check("cfg_err", cfg_err, e.err);
                @(negedge clockin);
                #1;
                if (!reset) check("clockout_second_half", clockout, e.out_b);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        model_reset();
        repeat (2) @(posedge clockin);
        #2;
        check("reset_clockout", clockout, 1'b0);
        check("reset_tick", tick, 1'b0);
        check("reset_cfg_pending", cfg_pending, 1'b0);
        check("reset_cfg_err", cfg_err, 1'b0);
        reset = 1'b0;

        repeat (12) step(1, 0, 0, 0, 0);

        idle_to_pos(1);
        step(1, 1, 5, 1, 0);
        repeat (14) step(1, 0, 0, 0, 0);

        step(1, 1, 3, 0, 1);
        repeat (15) step(1, 0, 0, 0, 0);

        step(1, 1, 4, 4, 0);
        repeat (8) step(1, 0, 0, 0, 0);

        step(1, 1, 2, 1, 0);
        repeat (10) step(1, 0, 0, 0, 0);

        step(1, 1, 6, 3, 0);
        step(1, 1, 7, 2, 0);
        repeat (16) step(1, 0, 0, 0, 0);

        // Asynchronous reset while the output is high.
        guard = 0;
        while (!last_a && guard < 20) begin
            step(1, 0, 0, 0, 0);
            guard++;
        end
        reset = 1'b1;
        #1;
        check("reset_mid_clockout", clockout, 1'b0);
        check("reset_mid_tick", tick, 1'b0);
        repeat (2) @(posedge clockin);
        #2;
        reset = 1'b0;
        model_reset();
        repeat (12) step(1, 0, 0, 0, 0);

        idle_to_pos(1);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (8) step(1, 0, 0, 0, 0);

        step(0, 1, 5, 0, 1);
        repeat (12) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 6, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            bit en, ld, md;
            int n, h;
            en = ($urandom % 16) != 0;
            ld = ($urandom % 8) == 0;
            n  = int'($urandom_range(0, 9));
            h  = int'($urandom_range(0, n + 1));
            md = 1'($urandom % 2);
            step(en, ld, n, h, md);
        end
        step(1, 0, 0, 0, 0);

        repeat (2) @(posedge clockin);
        done = 1'b1;
        #12;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
